// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and default sizing for the UART TX arbiter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int UART_DW          = 8;
    localparam int UART_GAP_DEFAULT = 16;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, first set request at or above ptr with wrap
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] pick
);

    int   idx;
    logic found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin share of one UART TX byte port
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DW         = UART_DW,
    parameter int GAP_CYCLES = UART_GAP_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic [N_REQ-1:0]    req_last,
    output logic [N_REQ-1:0]    req_ready,
    output logic                tx_valid,
    output logic [DW-1:0]       tx_data,
    input  logic                tx_ready,
    output logic [N_REQ-1:0]    gnt,
    output logic                busy
);

    localparam int PW = $clog2(N_REQ);
    // A zero-width counter is illegal, so the gapless build keeps one unused bit.
    localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    arb_state_t        state;
    logic [PW-1:0]     rr_ptr;
    logic [CW-1:0]     gap_cnt;
    logic [N_REQ-1:0]  pick;
    logic [PW-1:0]     g_idx;
    logic [PW-1:0]     next_ptr;
    logic              in_busy;
    logic              accept;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .pick (pick)
    );

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                g_idx = PW'(i);
            end
        end
    end

    assign in_busy   = (state == BUSY);
    assign tx_data   = req_data[g_idx*DW +: DW];
    assign tx_valid  = in_busy && req_valid[g_idx];
    assign req_ready = in_busy ? (gnt & {N_REQ{tx_ready}}) : '0;
    assign accept    = tx_valid && tx_ready;
    assign busy      = (state != IDLE);
    assign next_ptr  = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            rr_ptr  <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        gnt   <= pick;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept && req_last[g_idx]) begin
                        rr_ptr <= next_ptr;
                        gnt    <= '0;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= CW'(GAP_CYCLES - 1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench with a packet-level round-robin reference model
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int GAP = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_valid;
    logic [DW-1:0]   tx_data;
    logic            tx_ready;
    logic [N-1:0]    gnt;
    logic            busy;

    logic [N-1:0]    b_req_valid;
    logic [N*DW-1:0] b_req_data;
    logic [N-1:0]    b_req_last;
    logic [N-1:0]    b_req_ready;
    logic            b_tx_valid;
    logic [DW-1:0]   b_tx_data;
    logic            b_tx_ready;
    logic [N-1:0]    b_gnt;
    logic            b_busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .DW(DW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .gnt(gnt), .busy(busy)
    );

    uart_tx_arbiter #(.N_REQ(N), .DW(DW), .GAP_CYCLES(0)) dut_nogap (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_data(b_req_data), .req_last(b_req_last), .req_ready(b_req_ready),
        .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(b_tx_ready),
        .gnt(b_gnt), .busy(b_busy)
    );

    typedef struct {
        int         req;
        logic [7:0] data;
        logic       last;
    } beat_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [8:0] mem [N][64];
    int         len [N];
    int         rd  [N];
    beat_t      exp_q [$];
    logic       pat [8];
    int         npat;
    int         pidx;

    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            assert ($onehot0(gnt) && $onehot0(b_gnt)) else begin
                n_bad++;
                $display("FAIL gnt_onehot: gnt=%b gnt_nogap=%b required at most one bit set", gnt, b_gnt);
            end
        end
    end

    task automatic apply_reset();
        rst         = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        tx_ready    = 1'b0;
        b_req_valid = '0;
        b_req_data  = '0;
        b_req_last  = '0;
        b_tx_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            len[i] = 0;
            rd[i]  = 0;
        end
        npat = 0;
    endtask

    task automatic add_byte(input int r, input logic [7:0] d, input logic last);
        mem[r][len[r]] = {last, d};
        len[r]++;
    endtask

    task automatic add_rand_packet(input int r, input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            add_byte(r, 8'($urandom), (k == nbytes - 1));
        end
    endtask

    // Whole-packet round robin: every requester with queued packets is contending at each arbitration.
    task automatic build_model();
        int    ptr;
        int    w;
        int    pos [N];
        beat_t b;
        ptr = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) pos[i] = 0;
        while (1) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && pos[(ptr + k) % N] < len[(ptr + k) % N]) w = (ptr + k) % N;
            end
            if (w < 0) break;
            do begin
                b.req  = w;
                b.data = mem[w][pos[w]][7:0];
                b.last = mem[w][pos[w]][8];
                exp_q.push_back(b);
                pos[w]++;
            end while (!b.last && pos[w] < len[w]);
            ptr = (w + 1) % N;
        end
    endtask

    task automatic run_engine(input string name, input bit bubbles, input int ready_mode,
                              output int bus_cycles);
        int         gap_obs;
        int         idle_obs;
        bit         started;
        bit         done;
        bit         finished;
        logic [N-1:0] prev_gnt;
        logic [N-1:0] hs;
        logic [N-1:0] exp_rr;
        beat_t      e;
        bus_cycles = 0;
        gap_obs    = 0;
        idle_obs   = 0;
        started    = 1'b0;
        done       = 1'b0;
        finished   = 1'b0;
        prev_gnt   = '0;
        pidx       = 0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (rd[i] < len[i]) begin
                    bit first;
                    first = (rd[i] == 0) || mem[i][rd[i]-1][8];
                    req_valid[i] = first || !bubbles || ($urandom_range(3) != 0);
                    req_data[i*DW +: DW] = mem[i][rd[i]][7:0];
                    req_last[i] = mem[i][rd[i]][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_data[i*DW +: DW] = 8'($urandom);
                    req_last[i] = 1'($urandom);
                end
            end
            case (ready_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(1));
                default: begin
                    if (gnt != 0 && pidx < npat) begin
                        tx_ready = pat[pidx];
                        pidx++;
                    end else begin
                        tx_ready = 1'b1;
                    end
                end
            endcase
            @(negedge clk);
            hs     = req_ready & req_valid;
            exp_rr = tx_ready ? gnt : '0;
            n_cmp++;
            if (req_ready !== exp_rr) begin
                n_bad++;
                $display("FAIL %s req_ready cyc %0d: got %b expected %b", name, cyc, req_ready, exp_rr);
            end
            n_cmp++;
            if (tx_valid !== ((gnt & req_valid) != 0)) begin
                n_bad++;
                $display("FAIL %s tx_valid cyc %0d: got %b expected %b", name, cyc, tx_valid, (gnt & req_valid) != 0);
            end
            if (gnt != 0) begin
                bus_cycles++;
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s busy_while_granted cyc %0d: got %b expected 1", name, cyc, busy);
                end
            end
            if (gnt != 0 && prev_gnt == 0) begin
                n_cmp++;
                if (!started) begin
                    started = 1'b1;
                    if (cyc != 1) begin
                        n_bad++;
                        $display("FAIL %s first_grant_latency: got cycle %0d expected 1", name, cyc);
                    end
                end else if (gap_obs != GAP || idle_obs != 1) begin
                    n_bad++;
                    $display("FAIL %s inter_packet: got gap %0d idle %0d expected gap %0d idle 1", name, gap_obs, idle_obs, GAP);
                end
            end
            if (gnt == 0 && started) begin
                if (busy) gap_obs++;
                else idle_obs++;
            end
            if (tx_valid && tx_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s extra_beat: got data %h gnt %b expected no beat", name, tx_data, gnt);
                end else begin
                    e = exp_q.pop_front();
                    if (gnt !== (N'(1) << e.req) || tx_data !== e.data) begin
                        n_bad++;
                        $display("FAIL %s beat: got gnt %b data %h expected gnt %b data %h", name, gnt, tx_data, N'(1) << e.req, e.data);
                    end
                    if (e.last) begin
                        gap_obs  = 0;
                        idle_obs = 0;
                        if (exp_q.size() == 0) done = 1'b1;
                    end
                end
            end
            if (done && gnt == 0 && !busy) begin
                n_cmp++;
                finished = 1'b1;
                if (gap_obs != GAP) begin
                    n_bad++;
                    $display("FAIL %s tail_gap: got %0d expected %0d", name, gap_obs, GAP);
                end
            end
            prev_gnt = gnt;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (hs[i]) rd[i]++;
        end
        if (!finished) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got %0d beats outstanding expected 0", name, exp_q.size());
        end
        req_valid = '0;
        tx_ready  = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_last  = '1;
        tx_ready  = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (gnt !== '0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got gnt %b busy %b expected 0000 0", gnt, busy);
        end
        n_cmp++;
        if (tx_valid !== 1'b0 || req_ready !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got tx_valid %b req_ready %b expected 0 0000", tx_valid, req_ready);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (gnt !== '0 || busy !== 1'b0 || b_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got gnt %b busy %b nogap_busy %b expected 0000 0 0", gnt, busy, b_busy);
        end
    endtask

    task automatic test_single();
        int bc;
        apply_reset();
        clear_queues();
        add_byte(1, 8'hC3, 1'b0);
        add_byte(1, 8'h5A, 1'b0);
        add_byte(1, 8'h0F, 1'b1);
        build_model();
        run_engine("single", 1'b0, 0, bc);
        n_cmp++;
        if (bc != 3) begin
            n_bad++;
            $display("FAIL single_busy_cycles: got %0d expected 3", bc);
        end
    endtask

    task automatic test_contention();
        int bc;
        apply_reset();
        clear_queues();
        for (int i = 0; i < N; i++) add_byte(i, 8'(8'h10 + i), 1'b1);
        build_model();
        run_engine("contention", 1'b0, 0, bc);
    endtask

    task automatic test_fairness();
        int bc;
        apply_reset();
        clear_queues();
        add_rand_packet(0, 2);
        add_rand_packet(0, 2);
        add_rand_packet(2, 1);
        build_model();
        n_cmp++;
        if (exp_q.size() != 5 || exp_q[2].req != 2) begin
            n_bad++;
            $display("FAIL fairness_model: got size %0d third req %0d expected 5 2", exp_q.size(), exp_q[2].req);
        end
        run_engine("fairness", 1'b0, 0, bc);
    endtask

    task automatic test_backpressure();
        int bc;
        apply_reset();
        clear_queues();
        add_byte(3, 8'hA5, 1'b0);
        add_byte(3, 8'h3C, 1'b1);
        pat[0] = 1'b1;
        pat[1] = 1'b0;
        pat[2] = 1'b0;
        pat[3] = 1'b1;
        npat   = 4;
        build_model();
        run_engine("backpressure", 1'b0, 2, bc);
        n_cmp++;
        if (bc != 4) begin
            n_bad++;
            $display("FAIL backpressure_busy_cycles: got %0d expected 4", bc);
        end
    endtask

    task automatic test_reset_mid();
        int  bc;
        bit  accepted;
        apply_reset();
        accepted  = 1'b0;
        req_valid = 4'b0100;
        req_data  = '0;
        req_data[2*DW +: DW] = 8'h11;
        req_last  = 4'b0000;
        tx_ready  = 1'b1;
        for (int c = 0; c < 10 && !accepted; c++) begin
            @(negedge clk);
            if (tx_valid && tx_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        req_data[2*DW +: DW] = 8'h22;
        n_cmp++;
        if (!accepted || gnt !== 4'b0100) begin
            n_bad++;
            $display("FAIL midreset_pre: got accepted %b gnt %b expected 1 0100", accepted, gnt);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== '0 || tx_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            n_bad++;
            $display("FAIL midreset_async: got gnt %b tx_valid %b busy %b req_ready %b expected 0000 0 0 0000", gnt, tx_valid, busy, req_ready);
        end
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_queues();
        add_byte(2, 8'h77, 1'b1);
        add_byte(0, 8'h66, 1'b1);
        build_model();
        run_engine("after_midreset", 1'b0, 0, bc);
    endtask

    task automatic test_random();
        int bc;
        int total;
        for (int it = 0; it < 3; it++) begin
            apply_reset();
            clear_queues();
            total = 0;
            for (int i = 0; i < N; i++) begin
                int np;
                np = $urandom_range(2);
                for (int p = 0; p < np; p++) begin
                    add_rand_packet(i, $urandom_range(4, 1));
                    total++;
                end
            end
            if (total == 0) add_rand_packet($urandom_range(N - 1), 2);
            build_model();
            run_engine("random", 1'b1, 1, bc);
        end
    endtask

    task automatic test_no_gap();
        logic [N-1:0] eg [5];
        logic [N-1:0] hs;
        logic [7:0]   ed;
        apply_reset();
        eg = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
        b_req_valid = 4'b0011;
        b_req_data  = {8'h00, 8'h00, 8'hB2, 8'hA1};
        b_req_last  = 4'b0011;
        b_tx_ready  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (b_gnt !== eg[c] || b_busy !== (eg[c] != 0) || b_tx_valid !== (eg[c] != 0)) begin
                n_bad++;
                $display("FAIL nogap cyc %0d: got gnt %b busy %b tx_valid %b expected gnt %b", c, b_gnt, b_busy, b_tx_valid, eg[c]);
            end
            if (b_tx_valid && b_tx_ready) begin
                ed = (eg[c] == 4'b0001) ? 8'hA1 : 8'hB2;
                n_cmp++;
                if (b_tx_data !== ed) begin
                    n_bad++;
                    $display("FAIL nogap_data cyc %0d: got %h expected %h", c, b_tx_data, ed);
                end
            end
            hs = b_req_ready & b_req_valid;
            @(posedge clk);
            #1;
            b_req_valid = b_req_valid & ~hs;
        end
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        tx_ready    = 1'b0;
        b_req_valid = '0;
        b_req_data  = '0;
        b_req_last  = '0;
        b_tx_ready  = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_no_gap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
